// File: rtl/microinstruction_pipe_if.sv
// Handshake and data bundle between the microinstruction sequencer, the
// C/T pipeline register and the execution datapath.
interface microinstruction_pipe_if #(
    parameter int C_WIDTH = 6,
    parameter int T_WIDTH = 7,
    parameter int DEPTH   = 3
) ();
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [C_WIDTH-1:0] C_in;
    logic [T_WIDTH-1:0] T_in;
    logic               in_valid;
    logic               in_ready;
    logic [C_WIDTH-1:0] C_out;
    logic [T_WIDTH-1:0] T_out;
    logic               out_valid;
    logic               out_ready;
    logic               flush;
    logic [OCC_W-1:0]   occupancy;

    // Drives the pipe: sequencer side plus consumer ready and flush.
    modport master (
        output C_in, T_in, in_valid, out_ready, flush,
        input  in_ready, C_out, T_out, out_valid, occupancy
    );

    // The pipe itself.
    modport slave (
        input  C_in, T_in, in_valid, out_ready, flush,
        output in_ready, C_out, T_out, out_valid, occupancy
    );
endinterface

// File: rtl/microinstruction_pipe.sv
// Multi-stage C/T microinstruction pipeline register with per-stage valid
// bits, bubble-collapsing valid/ready handshake and synchronous flush.
// Empty or squashed stages always carry NOP_C/NOP_T, never stale data.
module microinstruction_pipe #(
    parameter int                 C_WIDTH = 6,
    parameter int                 T_WIDTH = 7,
    parameter int                 DEPTH   = 3,
    parameter logic [C_WIDTH-1:0] NOP_C   = '0,
    parameter logic [T_WIDTH-1:0] NOP_T   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    microinstruction_pipe_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0][C_WIDTH-1:0] c_q, c_d;
    logic [DEPTH-1:0][T_WIDTH-1:0] t_q, t_d;
    logic [OCC_W-1:0]              occ_q, occ_d;

    logic [DEPTH:0] rdy_s;
    logic           in_ready_s;
    logic           in_xfer_s;
    logic           out_xfer_s;

    // Ready chain from the consumer back to the input; a stage can load when
    // it is empty or when everything downstream of it is moving.
    always_comb begin
        rdy_s        = '0;
        rdy_s[DEPTH] = bus.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy_s[k] = ~valid_q[k] | rdy_s[k+1];
        end
        in_ready_s = rdy_s[0] & ~bus.flush & ~reset;
        in_xfer_s  = bus.in_valid & in_ready_s;
        out_xfer_s = valid_q[DEPTH-1] & bus.out_ready;
    end

    // Next-state for every stage and the occupancy counter.
    always_comb begin
        valid_d = valid_q;
        c_d     = c_q;
        t_d     = t_q;
        occ_d   = occ_q;
        if (bus.flush) begin
            valid_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                c_d[k] = NOP_C;
                t_d[k] = NOP_T;
            end
            occ_d = '0;
        end else begin
            // Stage 0 takes the incoming microinstruction, or a NOP bubble.
            if (rdy_s[0]) begin
                valid_d[0] = in_xfer_s;
                c_d[0]     = in_xfer_s ? bus.C_in : NOP_C;
                t_d[0]     = in_xfer_s ? bus.T_in : NOP_T;
            end else begin
                valid_d[0] = valid_q[0];
                c_d[0]     = c_q[0];
                t_d[0]     = t_q[0];
            end
            // Later stages copy their predecessor; invalid ones already hold NOP.
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy_s[k]) begin
                    valid_d[k] = valid_q[k-1];
                    c_d[k]     = c_q[k-1];
                    t_d[k]     = t_q[k-1];
                end else begin
                    valid_d[k] = valid_q[k];
                    c_d[k]     = c_q[k];
                    t_d[k]     = t_q[k];
                end
            end
            occ_d = occ_q + OCC_W'(in_xfer_s) - OCC_W'(out_xfer_s);
        end
    end

    // State registers with synchronous active-high reset to the empty pipe.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                c_q[k] <= NOP_C;
                t_q[k] <= NOP_T;
            end
            occ_q <= '0;
        end else begin
            valid_q <= valid_d;
            c_q     <= c_d;
            t_q     <= t_d;
            occ_q   <= occ_d;
        end
    end

    // Outputs come straight from the last stage registers.
    assign bus.in_ready  = in_ready_s;
    assign bus.C_out     = c_q[DEPTH-1];
    assign bus.T_out     = t_q[DEPTH-1];
    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.occupancy = occ_q;
endmodule

// File: doc/microinstruction_pipe.md
Name: microinstruction_pipe

Overview:
Parametrised multi-stage pipeline register for microinstruction control fields C and T, with per-stage valid bits.
Uses a valid/ready handshake with bubble collapsing, so empty stages fill while the downstream end is stalled.
Supports a synchronous flush that squashes every in-flight microinstruction to NOP.
Sits between the microinstruction sequencer and the execution datapath and supersedes the fixed single-stage C/T register.

Parameters:
C_WIDTH, 6, width of control field C
T_WIDTH, 7, width of field T
DEPTH, 3, number of register stages (>=1)
NOP_C, 0, C value held in an empty or squashed stage
NOP_T, 0, T value held in an empty or squashed stage

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
C_in  input  C_WIDTH  C field of the incoming microinstruction
T_in  input  T_WIDTH  T field of the incoming microinstruction
in_valid  input  1  C_in/T_in carry a microinstruction
in_ready  output  1  pipe accepts the input this cycle
C_out  output  C_WIDTH  C field at the last stage
T_out  output  T_WIDTH  T field at the last stage
out_valid  output  1  last stage holds a valid microinstruction
out_ready  input  1  consumer accepts C_out/T_out this cycle
flush  input  1  squash all stages at the next edge
occupancy  output  clog2(DEPTH+1)  count of valid stages

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is "clock", reset port is "reset".
- Reset, sampled at a rising edge: every stage valid=0, C=NOP_C, T=NOP_T, occupancy=0.
  - Therefore out_valid=0, C_out=NOP_C, T_out=NOP_T.
  - in_ready is 0 while reset is high.
- Stage k (0..DEPTH-1) holds valid_k, c_k, t_k. Stage DEPTH-1 drives C_out, T_out and out_valid directly from registers; there is no combinational data path from input to output.
- Ready chain (combinational):
  - rdy_DEPTH = out_ready
  - rdy_k = ~valid_k | rdy_(k+1)
  - in_ready = rdy_0 & ~flush & ~reset
- Stage update at each edge, when not flushing and not in reset:
  - If rdy_k = 1, stage k loads stage k-1. For k=0 it loads C_in, T_in and valid = in_valid & in_ready.
  - An invalid incoming value loads NOP_C/NOP_T with valid=0.
  - If rdy_k = 0, stage k holds its contents.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Latency: with the pipe empty and out_ready held at 1, an input accepted at edge n appears with out_valid=1 after edge n+DEPTH-1, i.e. DEPTH cycles after presentation.
- Throughput: one microinstruction per cycle while out_ready=1.
- Full: all valid_k=1 and out_ready=0, so in_ready=0 and all stages hold.
  - When out_ready rises, the whole chain advances in the same cycle and in_ready=1 that cycle.
- Stall with bubbles: while out_ready=0, upstream invalid stages keep accepting until the pipe is full. Ordering is always preserved.
- Flush: at an edge where flush=1, all stages become valid=0 with NOP fields.
  - in_ready=0 that cycle, so no input is accepted or lost.
  - An output transfer in the flush cycle (out_valid & out_ready) still counts as delivered.
  - Flush and reset have the same effect on state.
- occupancy: registered. It is updated every edge as previous + input transfer − output transfer, and cleared by reset or flush.
  - It never exceeds DEPTH and never underflows.
- Fields of an invalid stage are always NOP_C/NOP_T, never stale data.
- Reset or flush mid-stream: no partial state survives. The first accepted input afterwards sees the full DEPTH latency.
- DEPTH=1: a single register stage with in_ready = (~out_valid | out_ready) & ~flush & ~reset.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, C_in=6'h2A, T_in=7'h55 -> out_valid=0, C_out=0, T_out=0, occupancy=0, in_ready=0; these inputs never appear at the output.
- Streaming: DEPTH=3, out_ready=1, inputs C=1..5 with T=C+7'h10 on consecutive cycles -> first out_valid 3 cycles after the first presentation, then C_out=1,2,3,4,5 on consecutive cycles, occupancy steady at 3.
- Back-pressure: out_ready=0, present C=1..4 -> in_ready=0 on the 4th, occupancy=3, C_out=1 held. Raise out_ready -> C=4 accepted that same cycle, outputs 1,2,3,4 in order with none lost.
- Bubble collapse: inject C=1, then 2 idle cycles, then C=2, with out_ready=0 -> after settling, valid_2..1 hold 1,2, occupancy=2, in_ready=1.
- Flush: pipe full with C=7,8,9, out_ready=1, flush=1 alongside in_valid with C=3 -> C=7 is delivered, C=3 is not accepted, next cycle out_valid=0, occupancy=0, C_out=NOP_C.
- Parameter sweep: DEPTH=1, C_WIDTH=8, T_WIDTH=4, NOP_C=8'hFF -> latency 1, C_out=8'hFF when empty, full-rate streaming with out_ready=1.
